// File: rtl/flag_scan_display.sv
// -----------------------------------------------------------------------------
// flag_scan_display
//
// Purpose:
//   Captures N_FLAGS ALU status bits and shows each one as a '0' or '1' on its
//   own digit of a multiplexed 7-segment display with N_DIGITS digits. Digits
//   that have no flag behind them show 'F'. The display is fed either from the
//   most recent flag sample (live) or from an accumulating sticky register.
//   The decimal point on the last digit is lit while sticky mode is selected.
//
// Parameters:
//   N_DIGITS     number of multiplexed digits (1..8)
//   N_FLAGS      number of flags shown (1..N_DIGITS); digit i shows flag i
//   REFRESH_DIV  clk cycles per scan step (>= 2)
//   BLINK_DIV    clk cycles per blink phase (>= 2, used with FLAG_BLINK_EN)
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active-low
//   flags_in    flag bits from the ALU (bit0=zero, bit1=carry, bit2=overflow)
//   flag_valid  one-cycle strobe: sample flags_in
//   clr_sticky  one-cycle strobe: clear the sticky register
//   mode        0 = show live flags, 1 = show sticky flags
//   sticky_q    accumulated (sticky) flag register
//   an          digit anodes, active-low, one-hot-low while a digit is lit
//   seg         segments, active-low, seg[0]=a .. seg[6]=g
//   dp          decimal point, active-low
//
// Handshake: flag_valid and clr_sticky are single-cycle strobes with no ready
// back-pressure; the block accepts every strobe on the clock edge it is high.
//
// Build option:
//   FLAG_BLINK_EN  when defined, a sticky flag that is no longer set in the
//                  live sample blinks (blanked on alternate BLINK_DIV phases)
//                  while sticky mode is selected. Undefined: steady display.
// -----------------------------------------------------------------------------
module flag_scan_display #(
    parameter int N_DIGITS    = 4,
    parameter int N_FLAGS     = 3,
    parameter int REFRESH_DIV = 100_000,
    parameter int BLINK_DIV   = 25_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLAGS-1:0]  flags_in,
    input  logic                flag_valid,
    input  logic                clr_sticky,
    input  logic                mode,
    output logic [N_FLAGS-1:0]  sticky_q,
    output logic [N_DIGITS-1:0] an,
    output logic [6:0]          seg,
    output logic                dp
);

    // -------------------------------------------------------------------------
    // Parameter sanity
    // -------------------------------------------------------------------------
    if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_digits
        $error("flag_scan_display: N_DIGITS must be in 1..8");
    end
    if (N_FLAGS < 1 || N_FLAGS > N_DIGITS) begin : g_bad_flags
        $error("flag_scan_display: N_FLAGS must be in 1..N_DIGITS");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh
        $error("flag_scan_display: REFRESH_DIV must be >= 2");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink
        $error("flag_scan_display: BLINK_DIV must be >= 2");
    end

    localparam int PW    = $clog2(REFRESH_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    // Segment patterns used for reset / blanking.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // -------------------------------------------------------------------------
    // Hex to 7-segment, active-low, seg[0]=a .. seg[6]=g
    // -------------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // Refresh prescaler: counts 0..REFRESH_DIV-1, tick on the last count
    // -------------------------------------------------------------------------
    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Scan index: advances once per tick, wraps N_DIGITS-1 -> 0
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (tick) begin
            if (idx == IDX_LAST) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Flag capture
    //   A clear and a new sample in the same cycle leave exactly the new
    //   sample in the sticky register, so no event is lost to the clear.
    // -------------------------------------------------------------------------
    logic [N_FLAGS-1:0] live_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q   <= '0;
            sticky_q <= '0;
        end else begin
            if (flag_valid) begin
                live_q <= flags_in;
            end
            sticky_q <= (clr_sticky ? '0 : sticky_q) |
                        (flag_valid ? flags_in : '0);
        end
    end

    // -------------------------------------------------------------------------
    // Per-digit views, widened to N_DIGITS so the scan index can address them
    // directly; digits beyond N_FLAGS read as zero in every view.
    // -------------------------------------------------------------------------
    logic [N_DIGITS-1:0] src_pad;    // value shown on each flag digit
    logic [N_DIGITS-1:0] has_flag;   // digit is backed by a flag
    logic [N_DIGITS-1:0] stale_pad;  // sticky but not in the live sample

    always_comb begin
        src_pad                = '0;
        has_flag               = '0;
        stale_pad              = '0;
        src_pad[N_FLAGS-1:0]   = mode ? sticky_q : live_q;
        has_flag[N_FLAGS-1:0]  = '1;
        stale_pad[N_FLAGS-1:0] = sticky_q & ~live_q;
    end

    // -------------------------------------------------------------------------
    // Blink phase (optional)
    // -------------------------------------------------------------------------
    logic blank;

`ifdef FLAG_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Only a flag digit showing a past-but-not-current event is blanked;
    // its anode is still driven so the scan timing is unchanged.
    assign blank = mode & blink_phase & stale_pad[idx];
`else
    logic unused_stale;
    assign unused_stale = ^stale_pad;
    assign blank        = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next display values for the digit currently addressed by the scan
    // -------------------------------------------------------------------------
    logic [3:0]          nib;
    logic [6:0]          seg_next;
    logic [N_DIGITS-1:0] an_next;
    logic                dp_next;

    always_comb begin
        nib = has_flag[idx] ? {3'b000, src_pad[idx]} : 4'hF;
        seg_next = blank ? SEG_BLANK : hex_to_seg(nib);
        for (int i = 0; i < N_DIGITS; i++) begin
            an_next[i] = (idx != IDX_W'(i));
        end
        // Decimal point marks sticky mode, shown on the last digit only.
        dp_next = ~(mode && (idx == IDX_LAST));
    end

    // -------------------------------------------------------------------------
    // Output registers: loaded on tick, held between ticks
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (tick) begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_flag_scan_display.sv
// -----------------------------------------------------------------------------
// tb_flag_scan_display
//
// Bench for flag_scan_display with N_DIGITS=4, N_FLAGS=3, REFRESH_DIV=4,
// BLINK_DIV=8. A reference model tracks the flag registers and derives each
// scan step from the count of clock edges since reset release. Define
// FLAG_BLINK_EN for both bench and design to exercise the blink build.
// -----------------------------------------------------------------------------
module tb_flag_scan_display;

    localparam int N_DIGITS    = 4;
    localparam int N_FLAGS     = 3;
    localparam int REFRESH_DIV = 4;
    localparam int BLINK_DIV   = 8;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N_FLAGS-1:0]  flags_in   = '0;
    logic                flag_valid = 1'b0;
    logic                clr_sticky = 1'b0;
    logic                mode       = 1'b0;
    logic [N_FLAGS-1:0]  sticky_q;
    logic [N_DIGITS-1:0] an;
    logic [6:0]          seg;
    logic                dp;

    flag_scan_display #(
        .N_DIGITS   (N_DIGITS),
        .N_FLAGS    (N_FLAGS),
        .REFRESH_DIV(REFRESH_DIV),
        .BLINK_DIV  (BLINK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flags_in  (flags_in),
        .flag_valid(flag_valid),
        .clr_sticky(clr_sticky),
        .mode      (mode),
        .sticky_q  (sticky_q),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    int total = 0;
    int bad   = 0;

    // ---------------------------------------------------------------- reference model
    // Edge e after release (1-based) is a scan step when e is a multiple of
    // REFRESH_DIV; step n = e/REFRESH_DIV shows digit (n-1) mod N_DIGITS using
    // the flag state from before that edge.
    int                  m_edges  = 0;
    logic [N_FLAGS-1:0]  m_live   = '0;
    logic [N_FLAGS-1:0]  m_sticky = '0;
    logic [N_DIGITS-1:0] m_an     = '1;
    logic [6:0]          m_seg    = SEG_BLANK;
    logic                m_dp     = 1'b1;

    always @(posedge clk or negedge rst) begin : model
        int                  e;
        int                  digit;
        int                  phase;
        logic [N_FLAGS-1:0]  src;
        logic [N_DIGITS-1:0] a;
        logic [6:0]          s;
        logic [N_FLAGS-1:0]  stk;
        if (!rst) begin
            m_edges  <= 0;
            m_live   <= '0;
            m_sticky <= '0;
            m_an     <= '1;
            m_seg    <= SEG_BLANK;
            m_dp     <= 1'b1;
        end else begin
            e = m_edges + 1;
            m_edges <= e;
            if (e % REFRESH_DIV == 0) begin
                digit = (e / REFRESH_DIV - 1) % N_DIGITS;
                src   = mode ? m_sticky : m_live;
                phase = ((e - 1) / BLINK_DIV) % 2;
                if (digit < N_FLAGS) begin
                    s = src[digit] ? SEG_1 : SEG_0;
`ifdef FLAG_BLINK_EN
                    if (mode && phase == 1 && m_sticky[digit] && !m_live[digit])
                        s = SEG_BLANK;
`endif
                end else begin
                    s = SEG_F;
                end
                a = '1;
                a[digit] = 1'b0;
                m_an  <= a;
                m_seg <= s;
                m_dp  <= !(mode && digit == N_DIGITS - 1);
            end
            stk = clr_sticky ? '0 : m_sticky;
            if (flag_valid) begin
                stk = stk | flags_in;
                m_live <= flags_in;
            end
            m_sticky <= stk;
        end
    end

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b0;
        flags_in = '0; flag_valid = 1'b0; clr_sticky = 1'b0; mode = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (an !== 4'b1111) begin bad++; $display("FAIL reset_an got=%b want=%b", an, 4'b1111); end
        total++; if (seg !== SEG_BLANK) begin bad++; $display("FAIL reset_seg got=%h want=%h", seg, SEG_BLANK); end
        total++; if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b want=1", dp); end
        total++; if (sticky_q !== 3'b000) begin bad++; $display("FAIL reset_sticky got=%b want=000", sticky_q); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (an !== 4'b1111) begin bad++; $display("FAIL reset_early_an got=%b want=1111", an); end
        @(negedge clk);
        total++; if (an !== 4'b1110) begin bad++; $display("FAIL reset_first_digit got=%b want=1110", an); end
        total++; if (seg !== SEG_0) begin bad++; $display("FAIL reset_first_seg got=%h want=%h", seg, SEG_0); end
    endtask

    task automatic test_live_scan();
        logic [11:0] exp_q[$];
        logic [11:0] exp;
        int          budget;
        flags_in = 3'b101; flag_valid = 1'b1; mode = 1'b0;
        @(negedge clk);
        flag_valid = 1'b0;
        repeat (N_DIGITS * REFRESH_DIV + 1) @(negedge clk);
        budget = 0;
        while (an !== 4'b1110 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        total++; if (an !== 4'b1110) begin bad++; $display("FAIL live_sync got=%b want=1110", an); end
        exp_q.push_back({4'b1110, SEG_1, 1'b1});
        exp_q.push_back({4'b1101, SEG_0, 1'b1});
        exp_q.push_back({4'b1011, SEG_1, 1'b1});
        exp_q.push_back({4'b0111, SEG_F, 1'b1});
        exp_q.push_back({4'b1110, SEG_1, 1'b1});
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== exp) begin
                bad++;
                $display("FAIL live_scan got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         an, seg, dp, exp[11:8], exp[7:1], exp[0]);
            end
            total++;
            if ({an, seg, dp} !== {m_an, m_seg, m_dp}) begin
                bad++;
                $display("FAIL live_model got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         an, seg, dp, m_an, m_seg, m_dp);
            end
            repeat (REFRESH_DIV) @(negedge clk);
        end
    endtask

    task automatic test_sticky();
        int dp_seen;
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0; flag_valid = 1'b1; flags_in = 3'b001;
        @(negedge clk);
        flags_in = 3'b010;
        @(negedge clk);
        flag_valid = 1'b0; mode = 1'b1;
        total++; if (sticky_q !== 3'b011) begin bad++; $display("FAIL sticky_acc got=%b want=011", sticky_q); end
        repeat (N_DIGITS * REFRESH_DIV + 1) @(negedge clk);
        dp_seen = 0;
        for (int c = 0; c < 2 * N_DIGITS * REFRESH_DIV; c++) begin
            total++;
            if ({an, seg, dp} !== {m_an, m_seg, m_dp}) begin
                bad++;
                $display("FAIL sticky_model got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         an, seg, dp, m_an, m_seg, m_dp);
            end
            if (an == 4'b0111) begin
                dp_seen++;
                total++; if (dp !== 1'b0) begin bad++; $display("FAIL sticky_dp got=%b want=0", dp); end
            end
            if (an == 4'b1101) begin
                total++; if (seg !== SEG_1) begin bad++; $display("FAIL sticky_digit1 got=%h want=%h", seg, SEG_1); end
            end
            @(negedge clk);
        end
        total++; if (dp_seen == 0) begin bad++; $display("FAIL sticky_last_digit_seen got=0 want>0"); end
    endtask

    task automatic test_clear_race();
        total++; if (sticky_q !== 3'b011) begin bad++; $display("FAIL race_pre got=%b want=011", sticky_q); end
        clr_sticky = 1'b1; flag_valid = 1'b1; flags_in = 3'b100;
        @(negedge clk);
        clr_sticky = 1'b0; flag_valid = 1'b0;
        total++; if (sticky_q !== 3'b100) begin bad++; $display("FAIL race_sticky got=%b want=100", sticky_q); end
        total++; if (sticky_q !== m_sticky) begin bad++; $display("FAIL race_model got=%b want=%b", sticky_q, m_sticky); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            total++;
            if ({an, seg, dp, sticky_q} !== {m_an, m_seg, m_dp, m_sticky}) begin
                bad++;
                $display("FAIL random c=%0d got an=%b seg=%h dp=%b stk=%b want an=%b seg=%h dp=%b stk=%b",
                         c, an, seg, dp, sticky_q, m_an, m_seg, m_dp, m_sticky);
            end
            flags_in   = N_FLAGS'($urandom_range(0, 7));
            flag_valid = ($urandom_range(0, 3) == 0);
            clr_sticky = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            @(negedge clk);
        end
        flag_valid = 1'b0; clr_sticky = 1'b0;
    endtask

    task automatic test_mid_reset();
        int budget;
        budget = 0;
        while (an !== 4'b1011 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        total++; if (an !== 4'b1011) begin bad++; $display("FAIL midrst_sync got=%b want=1011", an); end
        #2 rst = 1'b0;
        #1;
        total++; if (an !== 4'b1111) begin bad++; $display("FAIL midrst_an got=%b want=1111", an); end
        total++; if (seg !== SEG_BLANK) begin bad++; $display("FAIL midrst_seg got=%h want=%h", seg, SEG_BLANK); end
        total++; if (sticky_q !== 3'b000) begin bad++; $display("FAIL midrst_sticky got=%b want=000", sticky_q); end
        @(negedge clk);
        rst = 1'b1;
        repeat (REFRESH_DIV - 1) @(negedge clk);
        total++; if (an !== 4'b1111) begin bad++; $display("FAIL midrst_hold got=%b want=1111", an); end
        @(negedge clk);
        total++; if (an !== 4'b1110) begin bad++; $display("FAIL midrst_restart got=%b want=1110", an); end
        total++; if ({an, seg, dp} !== {m_an, m_seg, m_dp}) begin
            bad++;
            $display("FAIL midrst_model got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                     an, seg, dp, m_an, m_seg, m_dp);
        end
    endtask

`ifdef FLAG_BLINK_EN
    task automatic test_blink();
        int saw_on;
        int saw_off;
        mode = 1'b1; flag_valid = 1'b1; flags_in = 3'b001;
        @(negedge clk);
        flags_in = 3'b000;
        @(negedge clk);
        flag_valid = 1'b0;
        saw_on = 0; saw_off = 0;
        for (int c = 0; c < 8 * BLINK_DIV; c++) begin
            if (an == 4'b1110) begin
                total++;
                if (seg !== m_seg) begin bad++; $display("FAIL blink_model got=%h want=%h", seg, m_seg); end
                if (seg == SEG_1) saw_on++;
                if (seg == SEG_BLANK) saw_off++;
            end
            @(negedge clk);
        end
        total++; if (saw_on == 0) begin bad++; $display("FAIL blink_on got=0 want>0"); end
        total++; if (saw_off == 0) begin bad++; $display("FAIL blink_off got=0 want>0"); end
    endtask
`endif

    initial begin
        test_reset();
        test_live_scan();
        test_sticky();
        test_clear_race();
        test_random();
        test_mid_reset();
`ifdef FLAG_BLINK_EN
        test_blink();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
